// File: rtl/trace_dump_ctrl_if.sv
// trace_dump_ctrl_if
// Signal bundle between the trace dump controller and its neighbours:
// command processor (dump_req/ch_sel/dump_abort), capture block
// (capture_done/trace_end/clr_capture_done), channel sample RAMs
// (ram_en/ram_addr/ram_rdata) and the UART transmitter (tx_data/trmt/tx_done).
// master : the dump controller side.
// slave  : the environment side (command, capture, RAMs, UART).
interface trace_dump_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
);
    logic                     dump_req;
    logic [1:0]               ch_sel;
    logic                     dump_abort;
    logic                     capture_done;
    logic [ADDR_W-1:0]        trace_end;
    logic [NUM_CH-1:0]        ram_en;
    logic [ADDR_W-1:0]        ram_addr;
    logic [NUM_CH*DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0]        tx_data;
    logic                     trmt;
    logic                     tx_done;
    logic                     busy;
    logic                     dump_done;
    logic                     dump_err;
    logic                     clr_capture_done;

    modport master (
        input  dump_req, ch_sel, dump_abort, capture_done, trace_end,
        input  ram_rdata, tx_done,
        output ram_en, ram_addr, tx_data, trmt, busy, dump_done, dump_err,
        output clr_capture_done
    );

    modport slave (
        output dump_req, ch_sel, dump_abort, capture_done, trace_end,
        output ram_rdata, tx_done,
        input  ram_en, ram_addr, tx_data, trmt, busy, dump_done, dump_err,
        input  clr_capture_done
    );
endinterface

// File: rtl/trace_dump_ctrl.sv
// trace_dump_ctrl
// Reads one channel of the circular capture RAMs oldest-to-newest (starting
// at trace_end+1 and wrapping) and streams each byte to the UART with a
// trmt/tx_done handshake. A full dump ends with dump_done and
// clr_capture_done pulsing together to re-arm capture.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  trace_dump_ctrl_if.master (request, capture status, RAM read port,
//        UART handshake, status pulses)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for an acceptable dump_req
// READ    | ram_en/ram_addr presented for the current sample
// LATCH   | RAM output valid; capture byte into tx_data, launch trmt
// WAIT_TX | byte in flight; wait for tx_done (or dump_abort)
// DONE    | all samples sent; fire dump_done/clr_capture_done
module trace_dump_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
) (
    input  logic              clk,
    input  logic              rst,
    trace_dump_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, WAIT_TX, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_SMPL = '1;
    localparam logic [2:0]        CH_LIMIT  = 3'(NUM_CH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] smpl_cnt;
    logic [1:0]        ch_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              trmt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              accept, reject, step, latch, abort_now, finish;
    logic [DATA_W-1:0] rd_byte;
    logic [NUM_CH-1:0] en_d;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        step      = 1'b0;
        latch     = 1'b0;
        abort_now = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dump_req) begin
                    if (bus.capture_done && ({1'b0, bus.ch_sel} < CH_LIMIT)) begin
                        accept  = 1'b1;
                        state_d = READ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            READ: begin
                if (bus.dump_abort) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (bus.dump_abort) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else begin
                    latch   = 1'b1;
                    state_d = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // abort wins over a tx_done in the same cycle
                if (bus.dump_abort) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else if (bus.tx_done) begin
                    if (smpl_cnt == LAST_SMPL) begin
                        state_d = DONE;
                    end else begin
                        step    = 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the active channel's byte from the concatenated RAM outputs.
    always_comb begin
        rd_byte = '0;
        en_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 2'(c)) begin
                rd_byte = bus.ram_rdata[c*DATA_W +: DATA_W];
                en_d[c] = (state_q == READ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr   <= '0;
            smpl_cnt  <= '0;
            ch_q      <= '0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            trmt_q  <= latch;
            done_q  <= finish;
            err_q   <= reject;
            if (accept) begin
                ch_q     <= bus.ch_sel;
                rd_addr  <= bus.trace_end + 1'b1;
                smpl_cnt <= '0;
                busy_q   <= 1'b1;
            end
            if (step) begin
                rd_addr  <= rd_addr + 1'b1;
                smpl_cnt <= smpl_cnt + 1'b1;
            end
            if (latch) begin
                tx_data_q <= rd_byte;
            end
            if (abort_now || finish) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Address is parked at 0 whenever no dump is walking the RAM.
    assign bus.ram_en           = en_d;
    assign bus.ram_addr         = (state_q == IDLE || state_q == DONE) ? '0 : rd_addr;
    assign bus.tx_data          = tx_data_q;
    assign bus.trmt             = trmt_q;
    assign bus.busy             = busy_q;
    assign bus.dump_done        = done_q;
    assign bus.clr_capture_done = done_q;
    assign bus.dump_err         = err_q;
endmodule
